// File: rtl/instr_sequencer_if.sv
// ---------------------------------------------------------------------------
// instr_sequencer_if
//   Bus bundle between the instruction sequencer and its neighbours: the
//   instruction ROM (address out, same-cycle data back) and the register file
//   / ALU control (decoded register addresses, ALU op, write strobe).
//
//   master : sequencer side (drives rom_addr and the decode outputs)
//   slave  : ROM / datapath side (drives rom_data)
// ---------------------------------------------------------------------------
interface instr_sequencer_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);
    logic [PC_W-1:0]    rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic [2:0]         rf_ra;
    logic [2:0]         rf_rb;
    logic [2:0]         rf_wa;
    logic               rf_we;
    logic [2:0]         alu_op;

    modport master (
        output rom_addr, rf_ra, rf_rb, rf_wa, rf_we, alu_op,
        input  rom_data
    );

    modport slave (
        input  rom_addr, rf_ra, rf_rb, rf_wa, rf_we, alu_op,
        output rom_data
    );
endinterface

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Fetch/decode/execute controller for the 8-bit CPU. One instruction takes
//   three cycles (FETCH, DECODE, EXEC); an IDLE cycle is inserted only when
//   starting or after run drops. Supports free-run (run), single-step (step,
//   level-sensitive, one instruction per IDLE visit) and a terminal HALT.
//
//   clk, rst_n   : clock, synchronous active-low reset
//   run, step    : execution control
//   bus          : ROM address/data and decoded register-file / ALU controls
//   pc, ir       : program counter, instruction register
//   halted       : HALT has executed
//   illegal      : sticky undefined-opcode flag
//   retired      : saturating count of executed instructions
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = 8'h00,
    parameter int              RET_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                step,
    instr_sequencer_if.master   bus,
    output logic [PC_W-1:0]     pc,
    output logic [INSTR_W-1:0]  ir,
    output logic                halted,
    output logic                illegal,
    output logic [RET_W-1:0]    retired
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               halted_q, halted_d;
    logic               illegal_q, illegal_d;
    logic [RET_W-1:0]   retired_q, retired_d;

    logic [3:0] opcode;
    logic       op_jmp, op_nop, op_halt, op_bad;

    assign opcode  = ir_q[15:12];
    assign op_jmp  = (opcode == 4'h8);
    assign op_nop  = (opcode == 4'h9);
    assign op_halt = (opcode == 4'hF);
    // Every opcode with bit 3 set that is not JMP/NOP/HALT is undefined.
    assign op_bad  = opcode[3] && !op_jmp && !op_nop && !op_halt;

    // Decode fields are plain slices of ir so they are stable from DECODE on.
    assign bus.rom_addr = pc_q;
    assign bus.rf_wa    = ir_q[11:9];
    assign bus.rf_ra    = ir_q[8:6];
    assign bus.rf_rb    = ir_q[5:3];
    assign bus.alu_op   = ir_q[14:12];
    assign bus.rf_we    = (state_q == EXEC) && !opcode[3];

    assign pc      = pc_q;
    assign ir      = ir_q;
    assign halted  = halted_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        retired_d = retired_q;
        unique case (state_q)
            IDLE: begin
                // step only matters when run is low, so run|step covers both.
                if (run || step) state_d = FETCH;
            end
            FETCH: begin
                ir_d    = bus.rom_data;
                state_d = DECODE;
            end
            DECODE: begin
                state_d = EXEC;
            end
            EXEC: begin
                if (retired_q != '1) retired_d = retired_q + RET_W'(1);
                if (op_halt) begin
                    halted_d = 1'b1;
                    state_d  = HALT;
                end else begin
                    if (op_jmp) pc_d = PC_W'(ir_q[11:4]);
                    else        pc_d = pc_q + PC_W'(1);
                    if (op_bad) illegal_d = 1'b1;
                    state_d = run ? FETCH : IDLE;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic        halted, illegal;
    logic [15:0] retired;

    logic [15:0] rom [0:255];

    typedef struct packed {
        logic [2:0] wa;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [2:0] op;
    } wr_t;

    wr_t exp_q[$];
    int  pulse_cyc[$];
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;

    instr_sequencer_if #(.PC_W(8), .INSTR_W(16)) bus ();

    assign bus.rom_data = rom[bus.rom_addr];

    instr_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .step    (step),
        .bus     (bus.master),
        .pc      (pc),
        .ir      (ir),
        .halted  (halted),
        .illegal (illegal),
        .retired (retired)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Scoreboard: every write strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (bus.rf_we === 1'b1) begin
            total = total + 1;
            pulse_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_we pc=%h ir=%h", pc, ir);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if ({bus.rf_wa, bus.rf_ra, bus.rf_rb, bus.alu_op} !== e) begin
                    bad = bad + 1;
                    $display("FAIL we_fields got wa=%0d ra=%0d rb=%0d op=%0d want wa=%0d ra=%0d rb=%0d op=%0d",
                             bus.rf_wa, bus.rf_ra, bus.rf_rb, bus.alu_op, e.wa, e.ra, e.rb, e.op);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 256; i++) rom[i] = v;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0; run = 1'b0; step = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        fill(16'h9000);
        tick();
        rst_n = 1'b0; run = 1'b1; step = 1'b1;
        tick();
        tick();
        total = total + 1;
        if ({pc, ir, halted, illegal, retired} !== 43'd0) begin
            bad = bad + 1;
            $display("FAIL reset_regs pc=%h ir=%h halted=%b illegal=%b retired=%h want all 0", pc, ir, halted, illegal, retired);
        end
        total = total + 1;
        if ({bus.rf_we, bus.rf_wa, bus.rf_ra, bus.rf_rb, bus.alu_op, bus.rom_addr} !== 21'd0) begin
            bad = bad + 1;
            $display("FAIL reset_decode we=%b wa=%0d ra=%0d rb=%0d op=%0d addr=%h want 0",
                     bus.rf_we, bus.rf_wa, bus.rf_ra, bus.rf_rb, bus.alu_op, bus.rom_addr);
        end
        run = 1'b0; step = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_alu_jmp_halt();
        int c0, n;
        fill(16'h9000);
        rom[0] = 16'h0050;
        rom[1] = 16'h14C8;
        rom[2] = 16'h8050;
        rom[5] = 16'hF000;
        exp_q.push_back('{wa: 3'd0, ra: 3'd1, rb: 3'd2, op: 3'd0});
        exp_q.push_back('{wa: 3'd2, ra: 3'd3, rb: 3'd1, op: 3'd1});
        do_reset();
        pulse_cyc.delete();
        run = 1'b1;
        c0 = cyc;
        n = 0;
        while (pulse_cyc.size() < 2 && n < 40) begin tick(); n++; end
        total = total + 1;
        if (pulse_cyc.size() < 2) begin
            bad = bad + 1;
            $display("FAIL alu_pulses got %0d pulses want 2", pulse_cyc.size());
        end else begin
            total = total + 1;
            if (pulse_cyc[0] - c0 !== 3) begin
                bad = bad + 1;
                $display("FAIL first_latency got %0d want 3", pulse_cyc[0] - c0);
            end
            total = total + 1;
            if (pulse_cyc[1] - pulse_cyc[0] !== 3) begin
                bad = bad + 1;
                $display("FAIL pulse_spacing got %0d want 3", pulse_cyc[1] - pulse_cyc[0]);
            end
            tick();
            total = total + 1;
            if (pc !== 8'h02 || retired !== 16'd2) begin
                bad = bad + 1;
                $display("FAIL after_alu pc=%h retired=%0d want pc=02 retired=2", pc, retired);
            end
        end
        n = 0;
        while (halted !== 1'b1 && n < 30) begin tick(); n++; end
        total = total + 1;
        if (halted !== 1'b1 || pc !== 8'h05 || retired !== 16'd4) begin
            bad = bad + 1;
            $display("FAIL jmp_halt halted=%b pc=%h retired=%0d want 1 05 4", halted, pc, retired);
        end
        for (int i = 0; i < 20; i++) begin
            run  = 1'($urandom_range(0, 1));
            step = 1'($urandom_range(0, 1));
            tick();
        end
        run = 1'b0; step = 1'b0;
        total = total + 1;
        if (halted !== 1'b1 || pc !== 8'h05 || retired !== 16'd4 || exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL halt_sticky halted=%b pc=%h retired=%0d pending=%0d want 1 05 4 0",
                     halted, pc, retired, exp_q.size());
        end
    endtask

    task automatic test_step();
        fill(16'h9000);
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            repeat (9) tick();
            total = total + 1;
            if (pc !== 8'(k) || retired !== 16'(k) || dut.state_q !== 3'd0) begin
                bad = bad + 1;
                $display("FAIL step_%0d pc=%h retired=%0d state=%0d want pc=%0d retired=%0d state=0",
                         k, pc, retired, dut.state_q, k, k);
            end
        end
        // Held step: one instruction per IDLE visit (8 cycles = two visits).
        step = 1'b1;
        repeat (8) tick();
        step = 1'b0;
        repeat (6) tick();
        total = total + 1;
        if (pc !== 8'h05 || retired !== 16'd5) begin
            bad = bad + 1;
            $display("FAIL step_held pc=%h retired=%0d want 05 5", pc, retired);
        end
    endtask

    task automatic test_illegal();
        int n;
        fill(16'h9000);
        rom[0] = 16'hA000;
        rom[1] = 16'h0050;
        rom[2] = 16'hF000;
        exp_q.push_back('{wa: 3'd0, ra: 3'd1, rb: 3'd2, op: 3'd0});
        do_reset();
        run = 1'b1;
        n = 0;
        while (retired !== 16'd1 && n < 10) begin tick(); n++; end
        total = total + 1;
        if (illegal !== 1'b1 || exp_q.size() != 1) begin
            bad = bad + 1;
            $display("FAIL illegal_set illegal=%b pending=%0d want 1 1", illegal, exp_q.size());
        end
        n = 0;
        while (halted !== 1'b1 && n < 20) begin tick(); n++; end
        run = 1'b0;
        total = total + 1;
        if (illegal !== 1'b1 || pc !== 8'h02 || retired !== 16'd3 || exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL illegal_after illegal=%b pc=%h retired=%0d pending=%0d want 1 02 3 0",
                     illegal, pc, retired, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        int n;
        fill(16'h9000);
        rom[0] = 16'h8FF0;
        do_reset();
        run = 1'b1;
        n = 0;
        while (pc !== 8'hFF && n < 10) begin tick(); n++; end
        total = total + 1;
        if (pc !== 8'hFF) begin
            bad = bad + 1;
            $display("FAIL jmp_ff pc=%h want ff", pc);
        end
        n = 0;
        while (pc === 8'hFF && n < 10) begin tick(); n++; end
        run = 1'b0;
        total = total + 1;
        if (pc !== 8'h00) begin
            bad = bad + 1;
            $display("FAIL pc_wrap pc=%h want 00", pc);
        end
    endtask

    task automatic test_saturate();
        fill(16'h9000);
        do_reset();
        tick();
        dut.retired_q = 16'hFFFE;
        for (int k = 1; k <= 2; k++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            repeat (6) tick();
            total = total + 1;
            if (retired !== 16'hFFFF || pc !== 8'(k)) begin
                bad = bad + 1;
                $display("FAIL saturate_%0d retired=%h pc=%h want ffff %0d", k, retired, pc, k);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        fill(16'h9000);
        rom[0] = 16'h0050;
        exp_q.push_back('{wa: 3'd0, ra: 3'd1, rb: 3'd2, op: 3'd0});
        do_reset();
        run = 1'b1;
        n = 0;
        while (bus.rf_we !== 1'b1 && n < 10) begin tick(); n++; end
        total = total + 1;
        if (bus.rf_we !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL mid_exec_reached we=%b want 1", bus.rf_we);
        end
        rst_n = 1'b0;
        tick();
        total = total + 1;
        if (bus.rf_we !== 1'b0 || pc !== 8'h00 || retired !== 16'd0 || dut.state_q !== 3'd0 || ir !== 16'h0) begin
            bad = bad + 1;
            $display("FAIL reset_mid we=%b pc=%h retired=%0d state=%0d ir=%h want 0 00 0 0 0000",
                     bus.rf_we, pc, retired, dut.state_q, ir);
        end
        run = 1'b0;
        rst_n = 1'b1;
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL reset_mid_pending got %0d want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_alu_jmp_halt();
        test_step();
        test_illegal();
        test_wrap();
        test_saturate();
        test_reset_mid();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
